// File: rtl/round_ctrl.sv
// Game-round sequencer: filters the slow-domain countdown/progress values, sequences
// arm/ready/play/win/timeout, and drives the progress bar, flags and saturating score.
module round_ctrl #(
  parameter int unsigned ARM_CYCLES = 4,
  parameter int unsigned BAR_W      = 10,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               guess_valid,
  input  logic               guess_correct,
  input  logic [2:0]         countdown,
  input  logic [4:0]         progress,
  output logic               timer_resetn,
  output logic [2:0]         state,
  output logic [BAR_W-1:0]   led_bar,
  output logic               win,
  output logic               timeout,
  output logic [SCORE_W-1:0] score
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StArm     = 3'd1;
  localparam logic [2:0] StReady   = 3'd2;
  localparam logic [2:0] StPlay    = 3'd3;
  localparam logic [2:0] StWin     = 3'd4;
  localparam logic [2:0] StTimeout = 3'd5;

  localparam int unsigned CntW = $clog2(ARM_CYCLES) + 2;

  logic [2:0]         cd_s1_q, cd_s2_q, cd_filt_q, cd_filt_d;
  logic [4:0]         pg_s1_q, pg_s2_q, pg_filt_q, pg_filt_d;
  logic [2:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [BAR_W-1:0]   led_q, led_d, therm;
  logic               win_q, win_d, timeout_q, timeout_d, tr_q, tr_d;

  // Filters only accept a value seen on two consecutive samples; ARM preloads the
  // values the downcounters reset to so a stale 0 cannot end READY early.
  always_comb begin
    cd_filt_d = cd_filt_q;
    pg_filt_d = pg_filt_q;
    if (state_q == StArm) begin
      cd_filt_d = 3'd5;
      pg_filt_d = 5'(BAR_W);
    end else begin
      if (cd_s1_q == cd_s2_q) cd_filt_d = cd_s2_q;
      if (pg_s1_q == pg_s2_q) pg_filt_d = pg_s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    case (state_q)
      StIdle:    if (start) state_d = StArm;
      StArm:     if (cnt_q == CntW'(ARM_CYCLES - 1)) state_d = StReady;
      StReady:   if (cnt_q >= CntW'(2) && cd_filt_q == 3'd0) state_d = StPlay;
      StPlay: begin
        if (guess_valid && guess_correct) begin
          state_d = StWin;
          if (score_q != '1) score_d = score_q + 1'b1;
        end else if (pg_filt_q == 5'd0) begin
          state_d = StTimeout;
        end
      end
      StWin, StTimeout: if (start) state_d = StArm;
      default:   state_d = StIdle;
    endcase
  end

  // Dwell counter restarts on every state change and saturates.
  always_comb begin
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q != '1)   cnt_d = cnt_q + 1'b1;
    else                    cnt_d = cnt_q;
  end

  always_comb begin
    for (int i = 0; i < int'(BAR_W); i++) therm[i] = (int'(pg_filt_q) > i);
  end

  always_comb begin
    led_d = '0;
    case (state_q)
      StReady: led_d = '1;
      StPlay:  led_d = therm;
      StWin:   led_d = led_q;
      default: led_d = '0;
    endcase
    win_d     = (state_q == StWin);
    timeout_d = (state_q == StTimeout);
    tr_d      = (state_q == StReady) || (state_q == StPlay) ||
                (state_q == StWin)   || (state_q == StTimeout);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cd_s1_q   <= '0;
      cd_s2_q   <= '0;
      cd_filt_q <= '0;
      pg_s1_q   <= '0;
      pg_s2_q   <= '0;
      pg_filt_q <= '0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      score_q   <= '0;
      led_q     <= '0;
      win_q     <= 1'b0;
      timeout_q <= 1'b0;
      tr_q      <= 1'b0;
    end else begin
      cd_s1_q   <= countdown;
      cd_s2_q   <= cd_s1_q;
      cd_filt_q <= cd_filt_d;
      pg_s1_q   <= progress;
      pg_s2_q   <= pg_s1_q;
      pg_filt_q <= pg_filt_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score_q   <= score_d;
      led_q     <= led_d;
      win_q     <= win_d;
      timeout_q <= timeout_d;
      tr_q      <= tr_d;
    end
  end

  assign state        = state_q;
  assign score        = score_q;
  assign led_bar      = led_q;
  assign win          = win_q;
  assign timeout      = timeout_q;
  assign timer_resetn = tr_q;

endmodule
